// File: rtl/alu_pkg.sv
// Shared types for the multi-channel ALU: opcodes, responses and channel FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_ADD      = 3'd1,
        CMD_MULTIPLY = 3'd2,
        CMD_AND      = 3'd3,
        CMD_SUB      = 3'd4
    } command_names_t;

    typedef enum logic [1:0] {
        NO_RESPONSE = 2'd0,
        SUCCESS     = 2'd1,
        OVERFLOW    = 2'd2,
        ERROR       = 2'd3
    } response_names_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_EXEC      = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_RESPOND   = 3'd4
    } chan_state_t;

endpackage

// File: rtl/alu_channel_bank_if.sv
// Command/result bus of the channel bank: one valid/ready command port and one
// valid/ready result port per channel, packed across channels.
interface alu_channel_bank_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4
);
    import alu_pkg::*;

    logic            [CHANNELS-1:0]            in_valid;
    logic            [CHANNELS-1:0]            in_ready;
    command_names_t  [CHANNELS-1:0]            in_command;
    logic            [CHANNELS-1:0][WIDTH-1:0] in_data1;
    logic            [CHANNELS-1:0][WIDTH-1:0] in_data2;
    logic            [CHANNELS-1:0]            out_valid;
    logic            [CHANNELS-1:0]            out_ready;
    response_names_t [CHANNELS-1:0]            out_response;
    logic            [CHANNELS-1:0][WIDTH-1:0] out_data;

    // Command sources and result consumers
    modport master (
        output in_valid, in_command, in_data1, in_data2, out_ready,
        input  in_ready, out_valid, out_response, out_data
    );

    // The channel bank
    modport slave (
        input  in_valid, in_command, in_data1, in_data2, out_ready,
        output in_ready, out_valid, out_response, out_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves to the slot after each grant.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[PW'(idx)]) begin
                found            = 1'b1;
                grant[PW'(idx)]  = 1'b1;
                ptr_d            = (idx + 1 == N) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_channel_bank.sv
// Parametrised multi-channel ALU; channels share one registered multiplier via rr_arbiter.
// Build option: ALU_SATURATE_EN saturates out_data on OVERFLOW (ADD/MULTIPLY all-ones, SUB zero).
module alu_channel_bank
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4
) (
    input  logic              clock,
    input  logic              reset,
    alu_channel_bank_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
`ifdef ALU_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic [CHANNELS-1:0]            mul_req;
    logic [CHANNELS-1:0]            mul_grant;
    logic [CHANNELS-1:0]            exec_mul;
    logic [CHANNELS-1:0][WIDTH-1:0] opnd_a;
    logic [CHANNELS-1:0][WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0]               mul_a;
    logic [WIDTH-1:0]               mul_b;
    logic [PW-1:0]                  mul_q;

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (mul_req),
        .grant (mul_grant)
    );

    // At most one channel sits in EXEC with a multiply, so an OR-mux suffices
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (exec_mul[c]) begin
                mul_a = mul_a | opnd_a[c];
                mul_b = mul_b | opnd_b[c];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mul_q <= '0;
        end else if (|exec_mul) begin
            mul_q <= PW'(mul_a) * PW'(mul_b);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        chan_state_t     state_q;
        command_names_t  op_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH:0]   res_q;
        logic             in_ready_q;
        logic             out_valid_q;
        response_names_t  resp_q;
        logic [WIDTH-1:0] data_q;
        response_names_t  wb_resp;
        logic [WIDTH-1:0] wb_data;
        logic             wb_ovf;

        assign mul_req[c]  = (state_q == ST_ISSUE) && (op_q == CMD_MULTIPLY);
        assign exec_mul[c] = (state_q == ST_EXEC)  && (op_q == CMD_MULTIPLY);
        assign opnd_a[c]   = a_q;
        assign opnd_b[c]   = b_q;

        assign bus.in_ready[c]     = in_ready_q;
        assign bus.out_valid[c]    = out_valid_q;
        assign bus.out_response[c] = resp_q;
        assign bus.out_data[c]     = data_q;

        // Writeback: overflow detection and final result selection
        always_comb begin
            wb_resp = SUCCESS;
            wb_data = res_q[WIDTH-1:0];
            wb_ovf  = 1'b0;
            case (op_q)
                CMD_ADD, CMD_SUB: wb_ovf = res_q[WIDTH];
                CMD_MULTIPLY: begin
                    wb_data = mul_q[WIDTH-1:0];
                    wb_ovf  = |mul_q[PW-1:WIDTH];
                end
                CMD_AND: wb_ovf = 1'b0;
                default: begin
                    wb_resp = ERROR;
                    wb_data = '0;
                end
            endcase
            if (wb_ovf) begin
                wb_resp = OVERFLOW;
                if (SATURATE) begin
                    wb_data = (op_q == CMD_SUB) ? '0 : '1;
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_q     <= ST_IDLE;
                op_q        <= CMD_NOP;
                a_q         <= '0;
                b_q         <= '0;
                res_q       <= '0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
                resp_q      <= NO_RESPONSE;
                data_q      <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.in_valid[c]) begin
                            op_q <= bus.in_command[c];
                            a_q  <= bus.in_data1[c];
                            b_q  <= bus.in_data2[c];
                            if (bus.in_command[c] != CMD_NOP) begin
                                state_q    <= ST_ISSUE;
                                in_ready_q <= 1'b0;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (op_q != CMD_MULTIPLY || mul_grant[c]) begin
                            state_q <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        case (op_q)
                            CMD_ADD: res_q <= {1'b0, a_q} + {1'b0, b_q};
                            CMD_SUB: res_q <= {1'b0, a_q} - {1'b0, b_q};
                            CMD_AND: res_q <= {1'b0, a_q & b_q};
                            default: res_q <= '0;
                        endcase
                        state_q <= ST_WRITEBACK;
                    end
                    ST_WRITEBACK: begin
                        resp_q      <= wb_resp;
                        data_q      <= wb_data;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_RESPOND;
                    end
                    ST_RESPOND: begin
                        if (bus.out_ready[c]) begin
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                    default: begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_channel_bank.sv
// Bench for alu_channel_bank: directed scenarios plus random batches checked
// against a behavioural model of results, responses and round-robin latency.
module tb_alu_channel_bank;
    import alu_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned CH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   rr_ptr = 0;

    // Batch descriptor, filled before each run_batch call
    bit          ben [CH];
    logic [2:0]  bop [CH];
    logic [31:0] ba  [CH];
    logic [31:0] bb  [CH];

    alu_channel_bank_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    alu_channel_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU from the arithmetic rules
    function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [1:0] resp, output logic [31:0] data);
        longint unsigned wide;
        bit ovf;
        ovf  = 1'b0;
        resp = 2'd1;
        data = 32'h0;
        case (op)
            3'd1: begin
                wide = longint'(a) + longint'(b);
                data = wide[31:0];
                ovf  = wide > 64'hFFFF_FFFF;
            end
            3'd2: begin
                wide = longint'(a) * longint'(b);
                data = wide[31:0];
                ovf  = (wide >> 32) != 0;
            end
            3'd3: data = a & b;
            3'd4: begin
                data = a - b;
                ovf  = b > a;
            end
            default: begin
                resp = 2'd3;
                data = 32'h0;
            end
        endcase
        if (ovf) begin
            resp = 2'd2;
`ifdef ALU_SATURATE_EN
            data = (op == 3'd4) ? 32'h0 : 32'hFFFF_FFFF;
`endif
        end
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 15));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return 32'h1 << $urandom_range(0, 31);
        endcase
    endfunction

    // Launch all enabled channels at one edge, observe latency/results, then consume
    task automatic run_batch(input string name);
        int          exp_lat [CH];
        int          lat     [CH];
        logic [1:0]  eresp   [CH];
        logic [31:0] edata   [CH];
        int          k;
        int          last;
        k    = 0;
        last = 0;
        for (int c = 0; c < CH; c++) begin
            ref_alu(bop[c], ba[c], bb[c], eresp[c], edata[c]);
            exp_lat[c] = (ben[c] && bop[c] != 3'd0 && bop[c] != 3'd2) ? 3 : 0;
            lat[c]     = 0;
        end
        for (int i = 0; i < CH; i++) begin
            int c;
            c = (rr_ptr + i) % CH;
            if (ben[c] && bop[c] == 3'd2) begin
                exp_lat[c] = 3 + k;
                k++;
                last = c;
            end
        end
        if (k > 0) rr_ptr = (last + 1) % CH;

        for (int c = 0; c < CH; c++) begin
            bus.in_valid[c]   = ben[c];
            bus.in_command[c] = command_names_t'(bop[c]);
            bus.in_data1[c]   = ba[c];
            bus.in_data2[c]   = bb[c];
        end
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = '0;
        for (int cyc = 1; cyc <= int'(CH) + 4; cyc++) begin
            @(posedge clock);
            @(negedge clock);
            for (int c = 0; c < CH; c++) begin
                if (lat[c] == 0 && bus.out_valid[c]) lat[c] = cyc;
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (ben[c]) begin
                check_eq($sformatf("%s lat ch%0d", name, c), 64'(lat[c]), 64'(exp_lat[c]));
                if (exp_lat[c] != 0) begin
                    check_eq($sformatf("%s resp ch%0d", name, c), 64'(bus.out_response[c]), 64'(eresp[c]));
                    check_eq($sformatf("%s data ch%0d", name, c), 64'(bus.out_data[c]), 64'(edata[c]));
                end
            end
        end
        bus.out_ready = '1;
        @(posedge clock);
        @(negedge clock);
        bus.out_ready = '0;
        check_eq({name, " in_ready after consume"}, 64'(bus.in_ready), 64'(4'hF));
        check_eq({name, " out_valid after consume"}, 64'(bus.out_valid), 64'h0);
    endtask

    task automatic clear_batch();
        for (int c = 0; c < CH; c++) begin
            ben[c] = 1'b0;
            bop[c] = 3'd0;
            ba[c]  = 32'h0;
            bb[c]  = 32'h0;
        end
    endtask

    task automatic single(input int c, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string name);
        clear_batch();
        ben[c] = 1'b1;
        bop[c] = op;
        ba[c]  = a;
        bb[c]  = b;
        run_batch(name);
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, " out_valid"}, 64'(bus.out_valid), 64'h0);
        check_eq({name, " in_ready"}, 64'(bus.in_ready), 64'(4'hF));
        check_eq({name, " out_data"}, 64'(bus.out_data), 64'h0);
        check_eq({name, " out_response"}, 64'(bus.out_response), 64'h0);
    endtask

    initial begin
        logic [1:0]  eresp;
        logic [31:0] edata;
        logic [1:0]  hold_resp;
        logic [31:0] hold_data;
        int          waited;

        bus.in_valid   = '0;
        bus.in_command = '{default: CMD_NOP};
        bus.in_data1   = '0;
        bus.in_data2   = '0;
        bus.out_ready  = '0;
        clear_batch();

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b1;

        // Reset while ch0 is in EXEC: discarded immediately, pointer back to 0
        bus.in_valid[0]   = 1'b1;
        bus.in_command[0] = CMD_ADD;
        bus.in_data1[0]   = 32'd7;
        bus.in_data2[0]   = 32'd9;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = '0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midexec reset");
        @(negedge clock);
        reset  = 1'b1;
        rr_ptr = 0;
        repeat (5) @(negedge clock);
        check_eq("discarded cmd out_valid", 64'(bus.out_valid), 64'h0);

        single(0, 3'd1, 32'hFFFF_FFFF, 32'h1, "add ovf");
        single(0, 3'd1, 32'd2, 32'd3, "add 2+3");

        clear_batch();
        for (int c = 0; c < CH; c++) begin
            ben[c] = 1'b1;
            bop[c] = 3'd2;
            ba[c]  = 32'h10000;
            bb[c]  = 32'h10000;
        end
        run_batch("mul all");

        single(2, 3'd4, 32'd5, 32'd7, "sub 5-7");
        single(1, 3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, "and");
        single(1, 3'd6, 32'h1234, 32'h5678, "illegal op6");
        single(0, 3'd0, 32'h1, 32'h1, "nop");

        // Backpressure on ch3 with an ignored command arriving mid-hold
        ref_alu(3'd1, 32'h8000_0000, 32'h8000_0001, eresp, edata);
        bus.in_valid[3]   = 1'b1;
        bus.in_command[3] = CMD_ADD;
        bus.in_data1[3]   = 32'h8000_0000;
        bus.in_data2[3]   = 32'h8000_0001;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = '0;
        waited = 0;
        while (!bus.out_valid[3] && waited < 10) begin
            @(posedge clock);
            @(negedge clock);
            waited++;
        end
        check_eq("bp latency", 64'(waited), 64'd3);
        hold_resp = bus.out_response[3];
        hold_data = bus.out_data[3];
        check_eq("bp resp", 64'(hold_resp), 64'(eresp));
        check_eq("bp data", 64'(hold_data), 64'(edata));
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                bus.in_valid[3]   = 1'b1;
                bus.in_command[3] = CMD_SUB;
                bus.in_data1[3]   = 32'd1;
                bus.in_data2[3]   = 32'd2;
            end else begin
                bus.in_valid = '0;
            end
            @(posedge clock);
            @(negedge clock);
            check_eq($sformatf("bp hold resp %0d", i), 64'(bus.out_response[3]), 64'(eresp));
            check_eq($sformatf("bp hold data %0d", i), 64'(bus.out_data[3]), 64'(edata));
            check_eq($sformatf("bp in_ready %0d", i), 64'(bus.in_ready[3]), 64'h0);
        end
        bus.in_valid  = '0;
        bus.out_ready = 4'h8;
        @(posedge clock);
        @(negedge clock);
        bus.out_ready = '0;
        check_eq("bp release in_ready", 64'(bus.in_ready[3]), 64'h1);
        repeat (5) @(negedge clock);
        check_eq("bp ignored cmd", 64'(bus.out_valid[3]), 64'h0);

        // Random batches
        for (int n = 0; n < 60; n++) begin
            for (int c = 0; c < CH; c++) begin
                ben[c] = ($urandom_range(0, 3) != 0);
                bop[c] = ($urandom_range(0, 2) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
                ba[c]  = rnd_operand();
                bb[c]  = rnd_operand();
            end
            run_batch($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
